// File: rtl/accum_drain_if.sv
// Bundles the command, column-memory and output-stream signals of accum_drain.
// Ports: command (start/base_addr/num_rows, busy/done), column read
// (col_wr_en, rd_en/rd_addr, rd_data), output stream (out_valid/out_ready, out_data/out_last).
interface accum_drain_if #(
  parameter int ACCUM_ROW  = 256,
  parameter int DATA_WIDTH = 32
);
  localparam int ADDR_WIDTH = $clog2(ACCUM_ROW);

  // command side
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   num_rows;
  logic                  busy;
  logic                  done;

  // column memory side
  logic                  col_wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;

  // output stream
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;

  // master: whoever drives commands, owns the column and consumes the stream
  modport master (
    output start, base_addr, num_rows, col_wr_en, rd_data, out_ready,
    input  busy, done, rd_en, rd_addr, out_valid, out_data, out_last
  );

  // slave: the drain sequencer itself
  modport slave (
    input  start, base_addr, num_rows, col_wr_en, rd_data, out_ready,
    output busy, done, rd_en, rd_addr, out_valid, out_data, out_last
  );
endinterface

// File: rtl/accum_drain.sv
// Drains a contiguous (wrapping) run of rows from an accumulator column onto a valid/ready stream.
// Latency: start in cycle 0, first rd_en cycle 1, first out_valid cycle 3; 1 beat/cycle when unstalled.
// Backpressure: 3-entry skid FIFO with read credit (fifo_count + inflight < 3); reads pause, nothing dropped.
// Ports: clk, rstn (sync active-low), bus (accum_drain_if.slave: command, column read, output stream).
module accum_drain #(
  parameter int ACCUM_ROW  = 256,
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk,
  input  logic           rstn,
  accum_drain_if.slave   bus
);
  localparam int ADDR_WIDTH = $clog2(ACCUM_ROW);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(ACCUM_ROW - 1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_num;
  logic [ADDR_WIDTH:0]   r_issued;
  logic [ADDR_WIDTH:0]   r_popped;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_fifo [3];
  logic [1:0]            r_wr_idx;
  logic [1:0]            r_rd_idx;
  logic [1:0]            r_count;

  logic w_credit_ok;
  logic w_rd_en;
  logic w_last_issue;
  logic w_push;
  logic w_pop;
  logic w_valid;
  logic w_last;

  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

  // Credit counts the word already in flight so a full FIFO can always absorb it.
  // Uses only registered state, so out_ready never reaches rd_en combinationally.
  assign w_credit_ok  = ({1'b0, r_count} + {2'b00, r_inflight}) < 3'd3;
  assign w_rd_en      = (r_state == S_READ) && !bus.col_wr_en && w_credit_ok;
  assign w_last_issue = (r_issued == r_num - CNT_ONE);
  assign w_push       = r_inflight;
  assign w_valid      = (r_count != 2'd0);
  assign w_pop        = w_valid && bus.out_ready;
  // Head beat index equals the number of beats already popped.
  assign w_last       = w_valid && (r_popped == r_num - CNT_ONE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_num      <= '0;
      r_issued   <= '0;
      r_popped   <= '0;
      r_inflight <= 1'b0;
      r_wr_idx   <= 2'd0;
      r_rd_idx   <= 2'd0;
      r_count    <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        r_fifo[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_ptr    <= bus.base_addr;
            r_num    <= bus.num_rows;
            r_issued <= '0;
            r_popped <= '0;
            r_state  <= (bus.num_rows == '0) ? S_DONE : S_READ;
          end
        end
        S_READ: begin
          if (w_rd_en && w_last_issue) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Popping the last beat implies the FIFO empties and nothing is in flight.
          if (w_pop && w_last) begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_rd_en) begin
        r_ptr    <= (r_ptr == LAST_ROW) ? '0 : r_ptr + 1'b1;
        r_issued <= r_issued + CNT_ONE;
      end

      r_inflight <= w_rd_en;

      if (w_push) begin
        r_fifo[r_wr_idx] <= bus.rd_data;
        r_wr_idx         <= next_idx(r_wr_idx);
      end

      if (w_pop) begin
        r_rd_idx <= next_idx(r_rd_idx);
        r_popped <= r_popped + CNT_ONE;
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.busy      = (r_state == S_READ) || (r_state == S_DRAIN);
  assign bus.done      = (r_state == S_DONE);
  assign bus.rd_en     = w_rd_en;
  assign bus.rd_addr   = r_ptr;
  assign bus.out_valid = w_valid;
  assign bus.out_data  = r_fifo[r_rd_idx];
  assign bus.out_last  = w_last;
endmodule

// File: tb/tb_accum_drain.sv
// Randomised scoreboard bench for accum_drain with a behavioural column memory.
// Latency: checks first read/valid/done cycles on directed runs.
// Backpressure: random and directed out_ready stalls plus column-write collisions.
module tb_accum_drain;
  localparam int AR = 256;
  localparam int DW = 32;
  localparam int AW = 8;

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  accum_drain_if #(.ACCUM_ROW(AR), .DATA_WIDTH(DW)) bus();

  accum_drain #(.ACCUM_ROW(AR), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  logic [DW-1:0] mem [AR];
  beat_t         exp_q [$];
  logic [AW-1:0] addr_q [$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0 = 0;
  int first_rd = -1;
  int first_vld = -1;
  int done_cyc = -1;
  int rd_cnt = 0;
  int beats = 0;
  int dones = 0;
  int dones0 = 0;

  logic          rdy_rand = 1'b0;
  logic          rdy_val  = 1'b1;
  logic          cw_rand  = 1'b0;
  logic          cw_val   = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_dat = '0;
  logic          prev_last = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Column memory: registered read, one cycle of latency; contents never change.
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Input driver for the free-running handshake inputs.
  initial begin
    bus.out_ready = 1'b1;
    bus.col_wr_en = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      bus.out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_val;
      bus.col_wr_en = cw_rand ? ($urandom_range(0, 4) == 0) : cw_val;
    end
  end

  // Monitor: pops the scoreboard on every handshake and watches read behaviour.
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        check("rd_during_col_wr", bus.col_wr_en, 0);
        if (addr_q.size() == 0) check("rd_unexpected", bus.rd_en, 0);
        else check("rd_addr", bus.rd_addr, addr_q.pop_front());
      end
      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_data", bus.out_data, prev_dat);
        check("stall_last", bus.out_last, prev_last);
      end
      if (bus.out_valid && first_vld < 0) first_vld = cyc;
      if (bus.out_valid && bus.out_ready) begin
        beats++;
        if (exp_q.size() == 0) begin
          check("beat_unexpected", bus.out_valid, 0);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check("out_data", bus.out_data, b.d);
          check("out_last", bus.out_last, b.l);
        end
      end
      if (bus.done) begin
        dones++;
        done_cyc = cyc;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_dat   = bus.out_data;
      prev_last  = bus.out_last;
    end
  end

  task automatic start_run(input int base, input int num);
    first_rd  = -1;
    first_vld = -1;
    done_cyc  = -1;
    rd_cnt    = 0;
    dones0    = dones;
    t0        = cyc;
    bus.start     = 1'b1;
    bus.base_addr = base[AW-1:0];
    bus.num_rows  = num[AW:0];
    for (int i = 0; i < num; i++) begin
      beat_t b;
      b.d = mem[(base + i) % AR];
      b.l = (i == num - 1);
      exp_q.push_back(b);
      addr_q.push_back(AW'((base + i) % AR));
    end
    tick;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (dones == dones0 && n < 3000) begin
      tick;
      n++;
    end
    check({name, "_done"}, dones - dones0, 1);
    tick;
    check({name, "_leftover"}, exp_q.size() + addr_q.size(), 0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.num_rows  = '0;
    for (int i = 0; i < AR; i++) mem[i] = $urandom;
    mem[4] = 10; mem[5] = 20; mem[6] = 30; mem[7] = 40;

    // Reset state
    repeat (3) tick;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rd_en", bus.rd_en, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_out_data", bus.out_data, 0);
    rstn = 1'b1;
    tick;

    // Basic run, exact latency
    start_run(4, 4);
    wait_done("basic");
    check("basic_first_rd", first_rd - t0, 1);
    check("basic_first_vld", first_vld - t0, 3);
    check("basic_done_cyc", done_cyc - t0, 7);
    check("basic_rd_cnt", rd_cnt, 4);

    // Backpressure: consumer stalled through cycle 8
    rdy_val = 1'b0;
    tick;
    start_run(4, 4);
    repeat (8) tick;
    check("bp_reads_outstanding", rd_cnt, 3);
    check("bp_head_held", bus.out_data, 10);
    rdy_val = 1'b1;
    wait_done("bp");

    // Column-write collision in cycles 2-3
    start_run(4, 4);
    tick;
    cw_val = 1'b1;
    tick;
    check("cw_addr_held", bus.rd_addr, 5);
    check("cw_rd_blocked", bus.rd_en, 0);
    tick;
    cw_val = 1'b0;
    wait_done("cw");
    check("cw_done_cyc", done_cyc - t0, 9);

    // Address wrap
    start_run(254, 4);
    wait_done("wrap");

    // Zero length
    start_run(0, 0);
    wait_done("zero");
    check("zero_no_rd", rd_cnt, 0);
    check("zero_no_valid", first_vld >= 0, 0);
    check("zero_done_cyc", done_cyc - t0, 1);

    // Full column with random stalls and collisions
    rdy_rand = 1'b1;
    cw_rand  = 1'b1;
    start_run(0, AR);
    wait_done("full");
    check("full_rd_cnt", rd_cnt, AR);

    // Start while busy is ignored
    start_run(10, 20);
    repeat (3) tick;
    bus.start = 1'b1; bus.base_addr = 8'd100; bus.num_rows = 9'd5;
    tick;
    bus.start = 1'b0;
    wait_done("ignore");

    // Reset mid-run
    rdy_rand = 1'b0;
    cw_rand  = 1'b0;
    rdy_val  = 1'b1;
    begin
      int b0, n;
      b0 = beats;
      n  = 0;
      start_run(30, 10);
      while (beats - b0 < 2 && n < 200) begin
        tick;
        n++;
      end
      check("rst_mid_beats", beats - b0 >= 2, 1);
    end
    rdy_val = 1'b0;
    rstn    = 1'b0;
    tick;
    rstn = 1'b1;
    exp_q.delete();
    addr_q.delete();
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_valid", bus.out_valid, 0);
    dones0 = dones;
    repeat (6) tick;
    check("rst_mid_no_done", dones - dones0, 0);
    rdy_val = 1'b1;
    start_run(40, 6);
    wait_done("post_rst");

    // Random runs
    rdy_rand = 1'b1;
    cw_rand  = 1'b1;
    for (int r = 0; r < 8; r++) begin
      start_run($urandom_range(0, AR - 1), $urandom_range(1, 40));
      wait_done("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
